// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Two-entry valid/ready pipeline register. A word is taken only on an
//   in_valid & in_ready handshake and is held until the downstream stage takes it.
//   The main entry drives out_data. The skid entry absorbs one extra word, so the
//   upstream side still gets a full cycle of ready even when out_ready deasserts.
//   Because of this, in_ready is decoded from state flops only and has no
//   combinational path from out_ready.
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_rst        synchronous active-high reset; takes priority over everything else
//   i_flush      synchronous kill of all held entries
//   i_in_valid   upstream word valid
//   o_in_ready   block can accept a word this cycle (decoded from state flops)
//   i_in_data    upstream payload
//   o_out_valid  o_out_data valid (decoded from state flops)
//   i_out_ready  downstream accepts o_out_data this cycle
//   o_out_data   oldest held word (main entry)
//   o_count      number of held words: 0, 1 or 2
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_count
);

  // The state encoding equals the occupancy, so o_count is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nxt_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_d;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_ld;
  logic             w_main_from_skid;
  logic             w_skid_ld;

  assign o_in_ready  = (r_state != TWO);
  assign o_out_valid = (r_state != EMPTY);
  assign o_count     = r_state;
  assign o_out_data  = r_main;

  assign w_in_fire  = i_in_valid & o_in_ready;
  assign w_out_fire = o_out_valid & i_out_ready;

  assign w_main_d = w_main_from_skid ? r_skid : i_in_data;

  always_comb begin
    w_nxt_state      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    if (i_flush) begin
      // Any handshake in the same cycle is discarded.
      // A downstream pop still counts as consumed.
      w_nxt_state = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_nxt_state = ONE;
            w_main_ld   = 1'b1;
          end
        end
        ONE: begin
          case ({w_in_fire, w_out_fire})
            2'b11: w_main_ld = 1'b1;
            2'b10: begin
              // Main is stalled, so the new word parks behind it.
              w_nxt_state = TWO;
              w_skid_ld   = 1'b1;
            end
            2'b01: w_nxt_state = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (w_out_fire) begin
            w_nxt_state      = ONE;
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_nxt_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_main_ld) r_main <= w_main_d;
      if (w_skid_ld) r_skid <= i_in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed-vector bench for pipe_skid_reg. Each table row drives the inputs for one
// cycle and gives the outputs expected after the following rising edge.
module tb_pipe_skid_reg;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int n_vec  = 0;
  int n_miss = 0;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         e_ov;
    logic         e_ir;
    logic [1:0]   e_cnt;
    logic         chk_d;   // compare out_data only when it is meaningful
    logic [W-1:0] e_d;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string nm, logic r, logic f, logic iv, logic [W-1:0] id,
                              logic ordy, logic ov, logic ir, logic [1:0] c,
                              logic cd, logic [W-1:0] d);
    vec_t v;
    v.name = nm; v.rst = r; v.flush = f; v.in_valid = iv; v.in_data = id;
    v.out_ready = ordy; v.e_ov = ov; v.e_ir = ir; v.e_cnt = c; v.chk_d = cd; v.e_d = d;
    tbl.push_back(v);
  endfunction

  // Drive one cycle of inputs, let the edge happen, then compare 1 time unit later.
  task automatic step(input string nm, input logic r, input logic f, input logic iv,
                      input logic [W-1:0] id, input logic ordy, input logic ov,
                      input logic ir, input logic [1:0] c, input logic cd,
                      input logic [W-1:0] d);
    rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== ov) begin
      n_miss++;
      $display("FAIL %s out_valid got %b want %b", nm, out_valid, ov);
    end
    if (in_ready !== ir) begin
      n_miss++;
      $display("FAIL %s in_ready got %b want %b", nm, in_ready, ir);
    end
    if (count !== c) begin
      n_miss++;
      $display("FAIL %s count got %0d want %0d", nm, count, c);
    end
    if (cd && out_data !== d) begin
      n_miss++;
      $display("FAIL %s out_data got %h want %h", nm, out_data, d);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //   name        rst flush iv  data       ordy  ov  ir  cnt chkd exp_data
    // T1: reset holds the block empty even with in_valid high.
    add("t1_rst0",   1, 0, 1, 32'h1234,  0,  0, 1, 0, 1, 32'h0);
    add("t1_rst1",   1, 0, 1, 32'h1234,  1,  0, 1, 0, 1, 32'h0);
    // T2: streaming with out_ready held high; occupancy stays at one.
    for (int k = 1; k <= 8; k++)
      add($sformatf("t2_s%0d", k), 0, 0, 1, 32'(k), 1, 1, 1, 1, 1, 32'(k));
    add("t2_end",    0, 0, 0, 32'h0,     1,  0, 1, 0, 0, 32'h0);
    // T3: backpressure fills both entries; the third word waits for space.
    add("t3_a5",     0, 0, 1, 32'hA5A5,  0,  1, 1, 1, 1, 32'hA5A5);
    add("t3_5a",     0, 0, 1, 32'h5A5A,  0,  1, 0, 2, 1, 32'hA5A5);
    add("t3_ffblk",  0, 0, 1, 32'hFFFF,  0,  1, 0, 2, 1, 32'hA5A5);
    add("t3_pop1",   0, 0, 1, 32'hFFFF,  1,  1, 1, 1, 1, 32'h5A5A);
    add("t3_pop2",   0, 0, 1, 32'hFFFF,  1,  1, 1, 1, 1, 32'hFFFF);
    add("t3_pop3",   0, 0, 0, 32'h0,     1,  0, 1, 0, 0, 32'h0);
    // T4: drain from two entries.
    add("t4_f1",     0, 0, 1, 32'h0C01,  0,  1, 1, 1, 1, 32'h0C01);
    add("t4_f2",     0, 0, 1, 32'h0C02,  0,  1, 0, 2, 1, 32'h0C01);
    add("t4_d1",     0, 0, 0, 32'h0,     1,  1, 1, 1, 1, 32'h0C02);
    add("t4_d2",     0, 0, 0, 32'h0,     1,  0, 1, 0, 0, 32'h0);
    // T5: a flush drops both entries and discards a concurrent offer.
    add("t5_f1",     0, 0, 1, 32'h1111,  0,  1, 1, 1, 1, 32'h1111);
    add("t5_f2",     0, 0, 1, 32'h2222,  0,  1, 0, 2, 1, 32'h1111);
    add("t5_flush",  0, 1, 1, 32'h3333,  0,  0, 1, 0, 0, 32'h0);
    add("t5_after",  0, 0, 0, 32'h0,     1,  0, 1, 0, 0, 32'h0);
    // Flush together with a downstream pop and an upstream offer still ends empty.
    add("t5b_fill",  0, 0, 1, 32'h4444,  0,  1, 1, 1, 1, 32'h4444);
    add("t5b_flpop", 0, 1, 1, 32'h5555,  1,  0, 1, 0, 0, 32'h0);
    add("t5b_next",  0, 0, 1, 32'h6666,  0,  1, 1, 1, 1, 32'h6666);
    // Reset takes priority over flush and clears the data registers.
    add("rst_flush", 1, 1, 1, 32'h7777,  1,  0, 1, 0, 1, 32'h0);
    // T6: a reset in the middle of operation, then normal traffic resumes.
    add("t6_beef",   0, 0, 1, 32'hBEEF,  0,  1, 1, 1, 1, 32'hBEEF);
    add("t6_rst",    1, 0, 0, 32'h0,     0,  0, 1, 0, 1, 32'h0);
    add("t6_nxt",    0, 0, 1, 32'h4242,  0,  1, 1, 1, 1, 32'h4242);
    add("t6_pop",    0, 0, 0, 32'h0,     1,  0, 1, 0, 0, 32'h0);

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].rst, tbl[i].flush, tbl[i].in_valid, tbl[i].in_data,
           tbl[i].out_ready, tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_cnt, tbl[i].chk_d, tbl[i].e_d);

    // Hand sequence: out_data stays stable under long backpressure while
    // the upstream side keeps changing its offer, and FIFO order survives the drain.
    step("hs_fill1", 0, 0, 1, 32'hCAFE0001, 0, 1, 1, 1, 1, 32'hCAFE0001);
    step("hs_fill2", 0, 0, 1, 32'hCAFE0002, 0, 1, 0, 2, 1, 32'hCAFE0001);
    for (int k = 0; k < 5; k++)
      step($sformatf("hs_hold%0d", k), 0, 0, k[0], 32'hDEAD0000 + 32'(k), 0,
           1, 0, 2, 1, 32'hCAFE0001);
    step("hs_pop1",  0, 0, 0, 32'h0, 1, 1, 1, 1, 1, 32'hCAFE0002);
    step("hs_stall", 0, 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'hCAFE0002);
    step("hs_pop2",  0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0);

    // Hand sequence: a refill from two entries while popping. The skid word moves
    // to main, and the new word is offered while in_ready is low, so it is ignored.
    step("hs2_f1",   0, 0, 1, 32'h0000AAAA, 0, 1, 1, 1, 1, 32'h0000AAAA);
    step("hs2_f2",   0, 0, 1, 32'h0000BBBB, 0, 1, 0, 2, 1, 32'h0000AAAA);
    step("hs2_pop",  0, 0, 1, 32'h0000CCCC, 1, 1, 1, 1, 1, 32'h0000BBBB);
    step("hs2_pop2", 0, 0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
